ucsbece154b_line_fill: RTL and testbench
========================================

# ucsbece154b_line_fill

Cache line-fill assembler that sits directly downstream of `ucsbece154b_fifo` on the memory-response path. It accepts one miss request at a time and pops `BLOCK_WORDS` response words from the FIFO, which arrive in critical-word-first wrap order. It forwards the critical word as soon as it lands (early restart), assembles the full line in address order, and hands the aligned line to the cache through a valid/ready handshake.

## Interface
- `DATA_WIDTH`, 32, word width; equals the FIFO `DATA_WIDTH`.
- `BLOCK_WORDS`, 4, words per line; a power of two, at least 2.
- `ADDR_WIDTH`, 32, byte-address width.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `req_valid_i`  in  1  miss request valid.
- `req_addr_i`  in  ADDR_WIDTH  byte address of the missing word.
- `req_ready_o`  out  1  block idle, request accepted.
- `fifo_data_i`  in  DATA_WIDTH  FIFO `data_o`.
- `fifo_valid_i`  in  1  FIFO `valid_o`.
- `fifo_pop_o`  out  1  FIFO `pop_i`.
- `word_o`  out  DATA_WIDTH  critical word.
- `word_valid_o`  out  1  critical word valid (one-cycle pulse).
- `line_o`  out  DATA_WIDTH*BLOCK_WORDS  assembled line; word i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `line_addr_o`  out  ADDR_WIDTH  line address with offset bits cleared.
- `line_valid_o`  out  1  line complete.
- `line_ready_i`  in  1  cache consumes the line.
- `busy_o`  out  1  a fill is in progress (state is not IDLE).

## Operation
- **Offset rules.** OFF = $clog2(BLOCK_WORDS). The critical index is crit = req_addr_i[OFF+1:2]. `line_addr_o` = req_addr_i with bits [OFF+1:0] zeroed. Both are registered on acceptance.
- **States.** The FSM has three states: IDLE, FILL, DONE.
  - IDLE: `req_ready_o`=1. If `req_valid_i` is high, latch crit and the address, clear the pop count, capture count and line buffer, then go to FILL.
  - FILL: `fifo_pop_o` = `fifo_valid_i` && (pop_cnt < BLOCK_WORDS). Each pop increments pop_cnt.
  - DONE: `line_valid_o`=1, held with `line_o` stable until `line_ready_i`=1, then go to IDLE.
- **FIFO read latency.** The FIFO registers its output on pop. A pop asserted in cycle t presents its word on `fifo_data_i` in cycle t+1. A one-bit register pop_q marks that cycle.
- **Capture.** When pop_q=1, write `fifo_data_i` into line slot (crit + cap_cnt) mod BLOCK_WORDS and increment cap_cnt. Counters are $clog2(BLOCK_WORDS)+1 bits wide; the slot index wraps modulo BLOCK_WORDS.
- **Early restart.** When pop_q=1 and cap_cnt=0, `word_o` = `fifo_data_i` and `word_valid_o`=1, combinationally, for exactly that cycle.
- **Completion.** Transition to DONE on the capture that brings cap_cnt to BLOCK_WORDS. No pops are issued after pop_cnt reaches BLOCK_WORDS.
- **FIFO stall.** If `fifo_valid_i`=0 in FILL, do not pop and wait indefinitely. Gaps between words are legal.
- **No acceptance outside IDLE.** Requests in FILL or DONE are not accepted; the requester holds `req_valid_i`.
- **Reset values.** All outputs are 0 except `req_ready_o`=1. FSM is in IDLE; counters, pop_q and line buffer are 0.
- **Reset mid-fill.** Return to IDLE immediately. A word in flight (pop_q set) is discarded. Any unpopped words are the FIFO's concern, because the FIFO is reset by the same `rst_i`.

## Timing
- Request accepted at the edge ending cycle 0. FILL starts in cycle 1.
- With the FIFO continuously valid:
  - pops occur in cycles 1..BLOCK_WORDS;
  - captures occur in cycles 2..BLOCK_WORDS+1;
  - `word_valid_o` pulses in cycle 2;
  - `line_valid_o` rises in cycle BLOCK_WORDS+2 (cycle 6 for the default).
- If `line_ready_i`=1 in the first DONE cycle, IDLE and `req_ready_o`=1 follow in the next cycle. Minimum request-to-request spacing is BLOCK_WORDS+3 cycles.
- `fifo_pop_o` depends combinationally on `fifo_valid_i` only. There is no combinational path from `line_ready_i` to `fifo_pop_o`.

## Test plan
- **Aligned fill.** Request 0x100, FIFO preloaded with A0,A1,A2,A3 (BLOCK_WORDS=4). Expect:
  - pops in cycles 1-4;
  - `word_o`=A0 with `word_valid_o` in cycle 2;
  - `line_o`={A3,A2,A1,A0} (word 0 in the low bits), `line_addr_o`=0x100, `line_valid_o` in cycle 6.
- **Wrapped fill.** Request 0x10C (crit=3), FIFO pushes W3,W0,W1,W2. Expect `word_o`=W3, and slots 0..3 = W0,W1,W2,W3 in address order.
- **FIFO bubbles.** Hold `fifo_valid_i` low for 3 cycles after the second pop. Expect `fifo_pop_o` to stay low during the bubble, the line to be correct, and `line_valid_o` 3 cycles later than in the unstalled case.
- **Backpressure.** Hold `line_ready_i` low for 5 cycles in DONE with a second request pending. Expect `line_o` stable, `req_ready_o`=0 throughout, and the second request accepted the cycle after the line is consumed.
- **Reset mid-fill.** Assert `rst_i` asynchronously after 2 captures. Expect all outputs at reset values immediately (`req_ready_o`=1), and a following aligned fill to complete correctly from a fresh FIFO.
- **Back-to-back fills.** Issue two back-to-back requests, 0x200 then 0x204. Expect two lines, `word_valid_o` exactly once per fill, and no extra pops beyond 8 total.

Source files
------------

// File: rtl/ucsbece154b_line_fill.sv
// Cache line-fill assembler: pops a critical-word-first burst from the response FIFO,
// forwards the critical word immediately and hands the address-ordered line to the cache.
`timescale 1ns/1ps

module ucsbece154b_line_fill #(
   parameter int DATA_WIDTH  = 32,
   parameter int BLOCK_WORDS = 4,
   parameter int ADDR_WIDTH  = 32
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic                              req_valid_i,
   input  logic [ADDR_WIDTH-1:0]             req_addr_i,
   output logic                              req_ready_o,
   input  logic [DATA_WIDTH-1:0]             fifo_data_i,
   input  logic                              fifo_valid_i,
   output logic                              fifo_pop_o,
   output logic [DATA_WIDTH-1:0]             word_o,
   output logic                              word_valid_o,
   output logic [DATA_WIDTH*BLOCK_WORDS-1:0] line_o,
   output logic [ADDR_WIDTH-1:0]             line_addr_o,
   output logic                              line_valid_o,
   input  logic                              line_ready_i,
   output logic                              busy_o
);

   localparam int OFF   = $clog2(BLOCK_WORDS);
   localparam int CNT_W = OFF + 1;
   localparam logic [CNT_W-1:0]      CNT_FULL = CNT_W'(BLOCK_WORDS);
   localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(BLOCK_WORDS - 1);
   localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
   localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'((1 << (OFF + 2)) - 1);

   typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [OFF-1:0]          r_crit;
   logic [ADDR_WIDTH-1:0]   r_addr;
   logic [CNT_W-1:0]        r_pop_cnt;
   logic [CNT_W-1:0]        r_cap_cnt;
   logic                    r_pop_q;
   logic [DATA_WIDTH-1:0]   r_buf [BLOCK_WORDS];

   logic                    w_accept;
   logic                    w_capture;
   logic                    w_first;
   logic [OFF-1:0]          w_slot;

   assign w_accept  = (r_state == S_IDLE) && req_valid_i;
   // pop_q marks the cycle in which the FIFO's registered output holds the popped word
   assign w_capture = (r_state == S_FILL) && r_pop_q;
   assign w_first   = w_capture && (r_cap_cnt == '0);
   // slot index wraps naturally in OFF bits, turning wrap order back into address order
   assign w_slot    = r_crit + r_cap_cnt[OFF-1:0];

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // NOTE: default assignment first, so no path through this block can infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (req_valid_i) w_state_nxt = S_FILL;
         S_FILL:  if (w_capture && (r_cap_cnt == CNT_LAST)) w_state_nxt = S_DONE;
         S_DONE:  if (line_ready_i) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      req_ready_o  = 1'b0;
      fifo_pop_o   = 1'b0;
      line_valid_o = 1'b0;
      busy_o       = (r_state != S_IDLE);
      word_valid_o = w_first;
      word_o       = w_first ? fifo_data_i : '0;
      case (r_state)
         S_IDLE:  req_ready_o  = 1'b1;
         S_FILL:  fifo_pop_o   = fifo_valid_i && (r_pop_cnt < CNT_FULL);
         S_DONE:  line_valid_o = 1'b1;
         default: ;
      endcase
   end

   // NOTE: the line buffer is reset like ordinary state because line_o must read zero out of reset.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_crit    <= '0;
         r_addr    <= '0;
         r_pop_cnt <= '0;
         r_cap_cnt <= '0;
         r_pop_q   <= 1'b0;
         for (int i = 0; i < BLOCK_WORDS; i++) r_buf[i] <= '0;
      end else begin
         r_pop_q <= fifo_pop_o;
         if (w_accept) begin
            r_crit    <= req_addr_i[OFF+1:2];
            r_addr    <= req_addr_i & ~OFF_MASK;
            r_pop_cnt <= '0;
            r_cap_cnt <= '0;
            for (int i = 0; i < BLOCK_WORDS; i++) r_buf[i] <= '0;
         end else begin
            if (fifo_pop_o) r_pop_cnt <= r_pop_cnt + CNT_ONE;
            if (w_capture) begin
               r_buf[w_slot] <= fifo_data_i;
               r_cap_cnt     <= r_cap_cnt + CNT_ONE;
            end
         end
      end
   end

   always_comb begin
      line_o = '0;
      for (int i = 0; i < BLOCK_WORDS; i++) line_o[i*DATA_WIDTH +: DATA_WIDTH] = r_buf[i];
   end

   assign line_addr_o = r_addr;

endmodule

// File: tb/tb_ucsbece154b_line_fill.sv
// Directed bench for ucsbece154b_line_fill: a vector table of single fills plus
// hand-written backpressure, reset-mid-fill and back-to-back sequences.
`timescale 1ns/1ps

module tb_ucsbece154b_line_fill;

   logic         clk_i;
   logic         rst_i;
   logic         req_valid_i;
   logic [31:0]  req_addr_i;
   logic         req_ready_o;
   logic [31:0]  fifo_data_i;
   logic         fifo_valid_i;
   logic         fifo_pop_o;
   logic [31:0]  word_o;
   logic         word_valid_o;
   logic [127:0] line_o;
   logic [31:0]  line_addr_o;
   logic         line_valid_o;
   logic         line_ready_i;
   logic         busy_o;

   ucsbece154b_line_fill dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .req_valid_i  (req_valid_i),
      .req_addr_i   (req_addr_i),
      .req_ready_o  (req_ready_o),
      .fifo_data_i  (fifo_data_i),
      .fifo_valid_i (fifo_valid_i),
      .fifo_pop_o   (fifo_pop_o),
      .word_o       (word_o),
      .word_valid_o (word_valid_o),
      .line_o       (line_o),
      .line_addr_o  (line_addr_o),
      .line_valid_o (line_valid_o),
      .line_ready_i (line_ready_i),
      .busy_o       (busy_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // Response FIFO model: output registered on pop, reset by the shared rst_i.
   logic [31:0] fifo_mem [32];
   int          wr_ptr;
   int          rd_ptr;
   logic        stall;

   assign fifo_valid_i = (wr_ptr != rd_ptr) && !stall;

   always @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd_ptr      <= 0;
         fifo_data_i <= '0;
      end else if (fifo_pop_o) begin
         fifo_data_i <= fifo_mem[rd_ptr % 32];
         rd_ptr      <= rd_ptr + 1;
      end
   end

   task automatic push(input logic [31:0] w);
      fifo_mem[wr_ptr % 32] = w;
      wr_ptr = wr_ptr + 1;
   endtask

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   typedef struct packed {
      logic [31:0]       addr;
      logic [3:0][31:0]  arr;        // arrival order, arr[0] first
      logic [127:0]      exp_line;
      logic [31:0]       exp_laddr;
      logic [31:0]       exp_word;
      int                stall_start;
      int                stall_len;
      int                exp_done;
      int                exp_last_pop;
   } vec_t;

   function automatic vec_t mk(input logic [31:0] addr, input logic [127:0] arr,
                               input logic [127:0] exp_line, input logic [31:0] laddr,
                               input logic [31:0] word, input int ss, input int sl,
                               input int done, input int last_pop);
      vec_t v;
      v.addr = addr; v.arr = arr; v.exp_line = exp_line; v.exp_laddr = laddr;
      v.exp_word = word; v.stall_start = ss; v.stall_len = sl;
      v.exp_done = done; v.exp_last_pop = last_pop;
      return v;
   endfunction

   task automatic check_reset_vals(input string tag);
      check({tag, " req_ready"},  128'(req_ready_o),  128'(1'b1));
      check({tag, " busy"},       128'(busy_o),       128'(1'b0));
      check({tag, " line_valid"}, 128'(line_valid_o), 128'(1'b0));
      check({tag, " word_valid"}, 128'(word_valid_o), 128'(1'b0));
      check({tag, " fifo_pop"},   128'(fifo_pop_o),   128'(1'b0));
      check({tag, " line_o"},     line_o,             128'(0));
      check({tag, " line_addr"},  128'(line_addr_o),  128'(0));
      check({tag, " word_o"},     128'(word_o),       128'(0));
   endtask

   // One fill from an idle block and an empty FIFO; the line is consumed in its first DONE cycle.
   task automatic run_fill(input vec_t v, input int id);
      int pops = 0, first_pop = -1, last_pop = -1, stall_pops = 0;
      int wv_n = 0, wv_cycle = -1, done = -1;
      logic [31:0] wv_val = '0;
      for (int k = 0; k < 4; k++) push(v.arr[k]);
      for (int c = 0; c < 40 && done < 0; c++) begin
         @(negedge clk_i);
         req_valid_i  = (c == 0);
         req_addr_i   = v.addr;
         line_ready_i = 1'b0;
         stall        = (c >= v.stall_start) && (c < v.stall_start + v.stall_len);
         #1;
         if (c == 0) check($sformatf("v%0d req_ready", id), 128'(req_ready_o), 128'(1'b1));
         if (fifo_pop_o) begin
            pops++;
            if (first_pop < 0) first_pop = c;
            last_pop = c;
            if (stall) stall_pops++;
         end
         if (word_valid_o) begin
            wv_n++;
            wv_cycle = c;
            wv_val   = word_o;
         end
         if (line_valid_o) done = c;
      end
      stall = 1'b0;
      check($sformatf("v%0d done_cycle", id), 128'(done),        128'(v.exp_done));
      check($sformatf("v%0d line_o", id),     line_o,            v.exp_line);
      check($sformatf("v%0d line_addr", id),  128'(line_addr_o), 128'(v.exp_laddr));
      check($sformatf("v%0d busy", id),       128'(busy_o),      128'(1'b1));
      check($sformatf("v%0d word_o", id),     128'(wv_val),      128'(v.exp_word));
      check($sformatf("v%0d word_cycle", id), 128'(wv_cycle),    128'(2));
      check($sformatf("v%0d word_pulses", id),128'(wv_n),        128'(1));
      check($sformatf("v%0d pops", id),       128'(pops),        128'(4));
      check($sformatf("v%0d first_pop", id),  128'(first_pop),   128'(1));
      check($sformatf("v%0d last_pop", id),   128'(last_pop),    128'(v.exp_last_pop));
      check($sformatf("v%0d stall_pops", id), 128'(stall_pops),  128'(0));
      line_ready_i = 1'b1;
      @(negedge clk_i);
      line_ready_i = 1'b0;
      #1;
      check($sformatf("v%0d idle_ready", id), 128'(req_ready_o),  128'(1'b1));
      check($sformatf("v%0d idle_lvalid", id),128'(line_valid_o), 128'(1'b0));
   endtask

   vec_t tbl [4];

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_i = 1'b1; req_valid_i = 1'b0; req_addr_i = '0; line_ready_i = 1'b0;
      stall = 1'b0; wr_ptr = 0;

      tbl[0] = mk(32'h100, {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000},
                  {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000},
                  32'h100, 32'hA000_0000, 0, 0, 6, 4);
      tbl[1] = mk(32'h10C, {32'hC0DE_0002, 32'hC0DE_0001, 32'hC0DE_0000, 32'hC0DE_0003},
                  {32'hC0DE_0003, 32'hC0DE_0002, 32'hC0DE_0001, 32'hC0DE_0000},
                  32'h100, 32'hC0DE_0003, 0, 0, 6, 4);
      tbl[2] = mk(32'h208, {32'h5A5A_0001, 32'h5A5A_0000, 32'h5A5A_0003, 32'h5A5A_0002},
                  {32'h5A5A_0003, 32'h5A5A_0002, 32'h5A5A_0001, 32'h5A5A_0000},
                  32'h200, 32'h5A5A_0002, 3, 3, 9, 7);
      tbl[3] = mk(32'h3F7, {32'hFFFF_00F0, 32'hFFFF_00F3, 32'hFFFF_00F2, 32'hFFFF_00F1},
                  {32'hFFFF_00F3, 32'hFFFF_00F2, 32'hFFFF_00F1, 32'hFFFF_00F0},
                  32'h3F0, 32'hFFFF_00F1, 0, 0, 6, 4);

      @(negedge clk_i);
      #1;
      check_reset_vals("reset");
      @(negedge clk_i);
      rst_i = 1'b0;

      for (int i = 0; i < 4; i++) run_fill(tbl[i], i);

      // Backpressure: line held 5 DONE cycles while a second request waits.
      begin
         int          ln2_cycle = -1;
         logic [127:0] ln2 = '0;
         logic [31:0]  la2 = '0;
         for (int k = 0; k < 4; k++) push(32'h1111_0000 + 32'(k));
         for (int k = 0; k < 4; k++) push(32'h2222_0000 + 32'(k));
         for (int c = 0; c < 25; c++) begin
            @(negedge clk_i);
            req_valid_i  = (c <= 12);
            req_addr_i   = (c == 0) ? 32'h400 : 32'h500;
            line_ready_i = (c == 11) || (c >= 13);
            #1;
            if (c >= 1 && c <= 11) check($sformatf("bp req_ready c%0d", c), 128'(req_ready_o), 128'(1'b0));
            if (c >= 5 && c <= 12) check($sformatf("bp no_pop c%0d", c), 128'(fifo_pop_o), 128'(1'b0));
            if (c >= 6 && c <= 11) begin
               check($sformatf("bp line_valid c%0d", c), 128'(line_valid_o), 128'(1'b1));
               check($sformatf("bp line_o c%0d", c), line_o,
                     {32'h1111_0003, 32'h1111_0002, 32'h1111_0001, 32'h1111_0000});
            end
            if (c == 6)  check("bp line_addr", 128'(line_addr_o), 128'(32'h400));
            if (c == 12) check("bp accept2", 128'(req_ready_o), 128'(1'b1));
            if (c == 13) check("bp busy2", 128'(busy_o), 128'(1'b1));
            if (c >= 13 && line_valid_o && ln2_cycle < 0) begin
               ln2_cycle = c; ln2 = line_o; la2 = line_addr_o;
            end
         end
         line_ready_i = 1'b0;
         req_valid_i  = 1'b0;
         check("bp line2_cycle", 128'(ln2_cycle), 128'(18));
         check("bp line2", ln2, {32'h2222_0003, 32'h2222_0002, 32'h2222_0001, 32'h2222_0000});
         check("bp line2_addr", 128'(la2), 128'(32'h500));
      end

      // Reset asserted asynchronously mid-fill, after two captures.
      begin
         for (int k = 0; k < 4; k++) push(32'h7777_0000 + 32'(k));
         for (int c = 0; c < 5; c++) begin
            @(negedge clk_i);
            req_valid_i = (c == 0);
            req_addr_i  = 32'h600;
            #1;
         end
         check("rst pre_busy", 128'(busy_o), 128'(1'b1));
         #1;
         rst_i  = 1'b1;
         wr_ptr = 0;
         #1;
         check_reset_vals("rst mid");
         @(negedge clk_i);
         rst_i = 1'b0;
         run_fill(tbl[0], 9);
      end

      // Back-to-back requests 0x200 then 0x204 with the line consumed immediately.
      begin
         int n_acc = 0, pop_n = 0, wv_n = 0, ln_n = 0;
         int acc_c [2];
         int ln_c [2];
         logic [31:0]  wv_v [2];
         logic [127:0] ln_v [2];
         logic [31:0]  la_v [2];
         for (int k = 0; k < 4; k++) push(32'hBEEF_0000 + 32'(k));
         push(32'hCAFE_0001); push(32'hCAFE_0002); push(32'hCAFE_0003); push(32'hCAFE_0000);
         for (int c = 0; c < 22; c++) begin
            @(negedge clk_i);
            req_valid_i  = (n_acc < 2);
            req_addr_i   = (n_acc == 0) ? 32'h200 : 32'h204;
            line_ready_i = 1'b1;
            #1;
            if (req_valid_i && req_ready_o) begin
               if (n_acc < 2) acc_c[n_acc] = c;
               n_acc++;
            end
            if (fifo_pop_o) pop_n++;
            if (word_valid_o) begin
               if (wv_n < 2) wv_v[wv_n] = word_o;
               wv_n++;
            end
            if (line_valid_o) begin
               if (ln_n < 2) begin
                  ln_c[ln_n] = c; ln_v[ln_n] = line_o; la_v[ln_n] = line_addr_o;
               end
               ln_n++;
            end
         end
         line_ready_i = 1'b0;
         req_valid_i  = 1'b0;
         check("b2b accepts", 128'(n_acc), 128'(2));
         check("b2b pops", 128'(pop_n), 128'(8));
         check("b2b word_pulses", 128'(wv_n), 128'(2));
         check("b2b lines", 128'(ln_n), 128'(2));
         if (n_acc == 2) check("b2b accept2_cycle", 128'(acc_c[1]), 128'(7));
         if (wv_n == 2) begin
            check("b2b word1", 128'(wv_v[0]), 128'(32'hBEEF_0000));
            check("b2b word2", 128'(wv_v[1]), 128'(32'hCAFE_0001));
         end
         if (ln_n == 2) begin
            check("b2b line1_cycle", 128'(ln_c[0]), 128'(6));
            check("b2b line2_cycle", 128'(ln_c[1]), 128'(13));
            check("b2b line1", ln_v[0], {32'hBEEF_0003, 32'hBEEF_0002, 32'hBEEF_0001, 32'hBEEF_0000});
            check("b2b line2", ln_v[1], {32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0000});
            check("b2b addr1", 128'(la_v[0]), 128'(32'h200));
            check("b2b addr2", 128'(la_v[1]), 128'(32'h200));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
